video_mixer_scanfx: RTL and testbench
=====================================

Name: video_mixer_scanfx

Overview:
- Parametrised successor to the single-depth mixer. Takes native-rate pixel stream (R/G/B, syncs, blanks, ce_pix) at generic input depth.
- Produces VGA-style output: pixel clock enable, optional scanline darkening, built-in OSD blend, registered DE/HS/VS, output depth chosen by parameter.
- Sits between core video generator (or external scandoubler) and board video DAC/HDMI encoder.

Parameters:
- IN_DEPTH, 6, bits per input colour component (1..8).
- OUT_DEPTH, 6, bits per output colour component (1..8); output = MSBs of 8-bit internal value.
- OSD_TINT, 8'h30, value added per channel when the matching osd_bkgr bit is set inside the OSD window.

Ports:
- CLK_VIDEO  in  1  video clock, at least 4x pixel rate.
- reset  in  1  asynchronous, active-high reset.
- ce_pix  in  1  input pixel clock or clock enable.
- R, G, B  in  IN_DEPTH each  input colour.
- HSync, VSync, HBlank, VBlank  in  1 each  positive pulses.
- scanline_mode  in  2  0 off, 1 = 75 %, 2 = 50 %, 3 = 25 % brightness on odd lines.
- osd_window  in  1  pixel inside OSD area.
- osd_pixel  in  1  OSD foreground pixel.
- osd_bkgr  in  3  OSD background tint enables {r,g,b}.
- CE_PIXEL  out  1  output pixel enable.
- VGA_R, VGA_G, VGA_B  out  OUT_DEPTH each  output colour.
- VGA_HS, VGA_VS, VGA_DE  out  1 each  output sync and data enable.

Behaviour:
- Reset (async, active-high) clears all registers. All outputs 0 during and after reset until the first CE_PIXEL. fs_osc = 0, line parity = 0.
- Stage 1, every clock:
  - Expand R/G/B to 8 bits by repeating MSB-first bit replication, e.g. IN_DEPTH = 6 gives {x, x[5:4]}; IN_DEPTH = 8 passes through.
  - Register hde = ~HBlank, vde = ~VBlank, hs = HSync, vs = VSync.
- CE detection:
  - ce_osc is set on any ce_pix change; it is sampled into fs_osc and cleared on each rising edge of registered vs.
  - CE_PIXEL is registered. When fs_osc = 1: CE_PIXEL = rising edge of ce_pix (one clock wide). When fs_osc = 0: CE_PIXEL = ce_pix (level).
  - First frame after reset therefore uses level mode.
- Line parity:
  - Toggles on each rising edge of stage-1 hs.
  - Forced to 0 on rising edge of stage-1 vs. If both edges occur in the same clock, vs wins and parity = 0.
- Stage 2, on CE_PIXEL only:
  - Blanking: colour = 0 when !hde or !vde.
  - Scanline (odd line and mode ≠ 0): mode 1 gives c − (c>>2); mode 2 gives c>>1; mode 3 gives c>>2. All arithmetic is 8-bit, never underflows.
  - OSD, applied after scanline and not scanlined:
    - If osd_window && osd_pixel: channel = 8'hFF.
    - Else if osd_window: channel = (c>>1) + (bkgr bit ? OSD_TINT : 0), saturating at 8'hFF.
  - VGA_HS/VGA_VS take stage-1 hs/vs.
  - VGA_DE updates only when hde changes between successive CE_PIXEL samples, to hde & vde. It holds otherwise, so vde changes mid-line take effect at the next hde edge.
- Latency: input to VGA_* is 2 CLK_VIDEO clocks plus wait for next CE_PIXEL. Syncs and colour stay aligned.
- VGA_R/G/B = internal[7:8−OUT_DEPTH].
- Reset mid-frame clears parity and fs_osc. The next frame after a vs edge re-detects CE mode.
- scanline_mode changes take effect on the next CE_PIXEL with no glitch.

Test Plan:
1. Reset asserted mid-line with ce_pix toggling → all outputs 0 immediately (asynchronous), CE_PIXEL stays 0 until reset is released. First frame runs in level mode.
2. IN_DEPTH = 6, OUT_DEPTH = 6, ce_pix toggling every 2 clocks, R = 6'h3F, G = 6'h20, B = 0, active area → after one frame CE_PIXEL is 1 clock wide per ce_pix rise, VGA_R = 6'h3F, VGA_G = 6'h20, VGA_B = 0.
3. scanline_mode = 2, R = 8'hC8 expanded input → even lines VGA_R carries 8'hC8, odd lines 8'h64. Line 0 after VSync rise is even, including when HSync and VSync rise together.
4. osd_window = 1, osd_pixel = 0, osd_bkgr = 3'b100, R = 8'hF0 → red = 8'h78 + 8'h30 = 8'hA8, G/B halved. With osd_pixel = 1 → all 8'hFF, regardless of scanline_mode = 3.
5. HBlank high, or VBlank high → colour 0. VGA_DE rises one CE_PIXEL after HBlank falls while VBlank is low. A VBlank change mid-line leaves DE unchanged until the next HBlank edge.
6. IN_DEPTH = 4, OUT_DEPTH = 3, R = 4'hA → internal 8'hAA, VGA_R = 3'b101. Overflow check: bkgr tint on 8'hFE input saturates at 8'hFF.

Source files
------------

// File: rtl/video_mixer_scanfx.sv
// Video output mixer: input depth expansion, CE detection, scanline darkening,
// OSD blend and registered VGA-style outputs at a configurable output depth.
module video_mixer_scanfx #(
  parameter int          IN_DEPTH  = 6,
  parameter int          OUT_DEPTH = 6,
  parameter logic [7:0]  OSD_TINT  = 8'h30
) (
  input  logic                 CLK_VIDEO,
  input  logic                 reset,
  input  logic                 ce_pix,
  input  logic [IN_DEPTH-1:0]  R,
  input  logic [IN_DEPTH-1:0]  G,
  input  logic [IN_DEPTH-1:0]  B,
  input  logic                 HSync,
  input  logic                 VSync,
  input  logic                 HBlank,
  input  logic                 VBlank,
  input  logic [1:0]           scanline_mode,
  input  logic                 osd_window,
  input  logic                 osd_pixel,
  input  logic [2:0]           osd_bkgr,
  output logic                 CE_PIXEL,
  output logic [OUT_DEPTH-1:0] VGA_R,
  output logic [OUT_DEPTH-1:0] VGA_G,
  output logic [OUT_DEPTH-1:0] VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_DE
);

  function automatic logic [7:0] expand(input logic [IN_DEPTH-1:0] x);
    logic [7:0] y;
    y = '0;
    for (int unsigned i = 0; i < 8; i++) y[7-i] = x[IN_DEPTH-1-(i % IN_DEPTH)];
    return y;
  endfunction

  // Blank, then scanline darkening, then OSD on top (OSD is never darkened).
  function automatic logic [7:0] mix(input logic [7:0] c, input logic blank, input logic odd,
                                     input logic [1:0] mode, input logic win, input logic pix,
                                     input logic tint_en);
    logic [7:0] s;
    logic [8:0] sum;
    s = blank ? 8'h00 : c;
    if (odd) begin
      case (mode)
        2'd1:    s = s - (s >> 2);
        2'd2:    s = s >> 1;
        2'd3:    s = s >> 2;
        default: s = s;
      endcase
    end
    sum = {1'b0, s >> 1} + {1'b0, (tint_en ? OSD_TINT : 8'h00)};
    if (win && pix)  s = 8'hFF;
    else if (win)    s = sum[8] ? 8'hFF : sum[7:0];
    return s;
  endfunction

  logic [7:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic       hde1_q, hde1_d, vde1_q, vde1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d;
  logic       win1_q, win1_d, pix1_q, pix1_d;
  logic [2:0] bkgr1_q, bkgr1_d;
  logic [1:0] mode1_q, mode1_d;
  logic       ce_prev_q, ce_prev_d, ce_osc_q, ce_osc_d, fs_osc_q, fs_osc_d;
  logic       parity_q, parity_d, hde_last_q, hde_last_d;
  logic       ce_out_q, ce_out_d, hs_out_q, hs_out_d, vs_out_q, vs_out_d, de_out_q, de_out_d;
  logic [OUT_DEPTH-1:0] r_out_q, r_out_d, g_out_q, g_out_d, b_out_q, b_out_d;
  logic       vs_rise, hs_rise, ce_now, blank, odd;
  logic [7:0] mix_r, mix_g, mix_b;

  always_comb begin
    r1_d      = expand(R);
    g1_d      = expand(G);
    b1_d      = expand(B);
    hde1_d    = ~HBlank;
    vde1_d    = ~VBlank;
    hs1_d     = HSync;
    vs1_d     = VSync;
    win1_d    = osd_window;
    pix1_d    = osd_pixel;
    bkgr1_d   = osd_bkgr;
    mode1_d   = scanline_mode;
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
    ce_prev_d = ce_pix;

    vs_rise = vs1_q & ~vs2_q;
    hs_rise = hs1_q & ~hs2_q;
    // A frame in which ce_pix ever toggled switches the next frame to edge mode.
    ce_now     = fs_osc_q ? (ce_pix & ~ce_prev_q) : ce_pix;
    ce_osc_d   = vs_rise ? 1'b0 : (ce_osc_q | (ce_pix ^ ce_prev_q));
    fs_osc_d   = vs_rise ? ce_osc_q : fs_osc_q;
    parity_d   = vs_rise ? 1'b0 : (parity_q ^ hs_rise);
    ce_out_d   = ce_now;

    blank = ~(hde1_q & vde1_q);
    odd   = parity_q & (mode1_q != 2'd0);
    mix_r = mix(r1_q, blank, odd, mode1_q, win1_q, pix1_q, bkgr1_q[2]);
    mix_g = mix(g1_q, blank, odd, mode1_q, win1_q, pix1_q, bkgr1_q[1]);
    mix_b = mix(b1_q, blank, odd, mode1_q, win1_q, pix1_q, bkgr1_q[0]);

    r_out_d    = r_out_q;
    g_out_d    = g_out_q;
    b_out_d    = b_out_q;
    hs_out_d   = hs_out_q;
    vs_out_d   = vs_out_q;
    de_out_d   = de_out_q;
    hde_last_d = hde_last_q;
    if (ce_now) begin
      r_out_d    = mix_r[7 -: OUT_DEPTH];
      g_out_d    = mix_g[7 -: OUT_DEPTH];
      b_out_d    = mix_b[7 -: OUT_DEPTH];
      hs_out_d   = hs1_q;
      vs_out_d   = vs1_q;
      hde_last_d = hde1_q;
      // DE only re-evaluates on horizontal blank edges so it stays line-aligned.
      if (hde1_q != hde_last_q) de_out_d = hde1_q & vde1_q;
    end
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      r1_q <= '0; g1_q <= '0; b1_q <= '0;
      hde1_q <= '0; vde1_q <= '0; hs1_q <= '0; vs1_q <= '0;
      hs2_q <= '0; vs2_q <= '0;
      win1_q <= '0; pix1_q <= '0; bkgr1_q <= '0; mode1_q <= '0;
      ce_prev_q <= '0; ce_osc_q <= '0; fs_osc_q <= '0;
      parity_q <= '0; hde_last_q <= '0;
      ce_out_q <= '0; hs_out_q <= '0; vs_out_q <= '0; de_out_q <= '0;
      r_out_q <= '0; g_out_q <= '0; b_out_q <= '0;
    end else begin
      r1_q <= r1_d; g1_q <= g1_d; b1_q <= b1_d;
      hde1_q <= hde1_d; vde1_q <= vde1_d; hs1_q <= hs1_d; vs1_q <= vs1_d;
      hs2_q <= hs2_d; vs2_q <= vs2_d;
      win1_q <= win1_d; pix1_q <= pix1_d; bkgr1_q <= bkgr1_d; mode1_q <= mode1_d;
      ce_prev_q <= ce_prev_d; ce_osc_q <= ce_osc_d; fs_osc_q <= fs_osc_d;
      parity_q <= parity_d; hde_last_q <= hde_last_d;
      ce_out_q <= ce_out_d; hs_out_q <= hs_out_d; vs_out_q <= vs_out_d; de_out_q <= de_out_d;
      r_out_q <= r_out_d; g_out_q <= g_out_d; b_out_q <= b_out_d;
    end
  end

  assign CE_PIXEL = ce_out_q;
  assign VGA_R    = r_out_q;
  assign VGA_G    = g_out_q;
  assign VGA_B    = b_out_q;
  assign VGA_HS   = hs_out_q;
  assign VGA_VS   = vs_out_q;
  assign VGA_DE   = de_out_q;

endmodule

// File: tb/tb_video_mixer_scanfx.sv
// Bench for video_mixer_scanfx: three parameterisations driven by one stream,
// checked every cycle against a pixel-level model plus hand-computed literals.
module tb_video_mixer_scanfx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce_pix = 1'b0;
  logic [7:0] rin = '0, gin = '0, bin = '0;
  logic hsync = 1'b0, vsync = 1'b0, hblank = 1'b1, vblank = 1'b1;
  logic [1:0] smode = '0;
  logic owin = 1'b0, opix = 1'b0;
  logic [2:0] obk = '0;
  logic [31:0] ce_cnt = '0;
  int n_tests = 0;
  int n_fail = 0;

  logic ce6, hs6, vs6, de6, ce8, hs8, vs8, de8, ce4, hs4, vs4, de4;
  logic [5:0] r6, g6, b6;
  logic [7:0] r8, g8, b8;
  logic [2:0] r4, g4, b4;

  always #5 clk = ~clk;

  video_mixer_scanfx #(.IN_DEPTH(6), .OUT_DEPTH(6), .OSD_TINT(8'h30)) dut6 (
    .CLK_VIDEO(clk), .reset(rst), .ce_pix(ce_pix), .R(rin[7:2]), .G(gin[7:2]), .B(bin[7:2]),
    .HSync(hsync), .VSync(vsync), .HBlank(hblank), .VBlank(vblank), .scanline_mode(smode),
    .osd_window(owin), .osd_pixel(opix), .osd_bkgr(obk), .CE_PIXEL(ce6),
    .VGA_R(r6), .VGA_G(g6), .VGA_B(b6), .VGA_HS(hs6), .VGA_VS(vs6), .VGA_DE(de6));

  video_mixer_scanfx #(.IN_DEPTH(8), .OUT_DEPTH(8), .OSD_TINT(8'h30)) dut8 (
    .CLK_VIDEO(clk), .reset(rst), .ce_pix(ce_pix), .R(rin), .G(gin), .B(bin),
    .HSync(hsync), .VSync(vsync), .HBlank(hblank), .VBlank(vblank), .scanline_mode(smode),
    .osd_window(owin), .osd_pixel(opix), .osd_bkgr(obk), .CE_PIXEL(ce8),
    .VGA_R(r8), .VGA_G(g8), .VGA_B(b8), .VGA_HS(hs8), .VGA_VS(vs8), .VGA_DE(de8));

  video_mixer_scanfx #(.IN_DEPTH(4), .OUT_DEPTH(3), .OSD_TINT(8'hA0)) dut4 (
    .CLK_VIDEO(clk), .reset(rst), .ce_pix(ce_pix), .R(rin[7:4]), .G(gin[7:4]), .B(bin[7:4]),
    .HSync(hsync), .VSync(vsync), .HBlank(hblank), .VBlank(vblank), .scanline_mode(smode),
    .osd_window(owin), .osd_pixel(opix), .osd_bkgr(obk), .CE_PIXEL(ce4),
    .VGA_R(r4), .VGA_G(g4), .VGA_B(b4), .VGA_HS(hs4), .VGA_VS(vs4), .VGA_DE(de4));

  // ---------------- model ----------------
  typedef struct packed {
    logic hde, vde, hs, vs;
    logic [7:0] r, g, b;
    logic win, pix;
    logic [2:0] bk;
    logic [1:0] mode;
  } samp_t;

  samp_t s1, s2, lat;
  logic m_prev_ce, m_toggled, m_edge, m_par, lat_odd, m_ce, m_de, m_last_hde;
  logic vsr, hsr, cenow;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 = '0; s2 = '0; lat = '0;
      m_prev_ce = 0; m_toggled = 0; m_edge = 0; m_par = 0;
      lat_odd = 0; m_ce = 0; m_de = 0; m_last_hde = 0;
    end else begin
      vsr = s1.vs && !s2.vs;
      hsr = s1.hs && !s2.hs;
      cenow = m_edge ? (ce_pix && !m_prev_ce) : ce_pix;
      if (cenow) begin
        if (s1.hde != m_last_hde) m_de = s1.hde && s1.vde;
        m_last_hde = s1.hde;
        lat = s1;
        lat_odd = m_par;
      end
      m_ce = cenow;
      if (vsr) begin
        m_edge = m_toggled;
        m_toggled = 0;
      end else if (ce_pix != m_prev_ce) m_toggled = 1;
      if (vsr) m_par = 0;
      else if (hsr) m_par = !m_par;
      m_prev_ce = ce_pix;
      s2 = s1;
      s1.hde = !hblank; s1.vde = !vblank; s1.hs = hsync; s1.vs = vsync;
      s1.r = rin; s1.g = gin; s1.b = bin;
      s1.win = owin; s1.pix = opix; s1.bk = obk; s1.mode = smode;
    end
  end

  function automatic int exp_chan(input int raw, input int ind, input int outd, input int tint,
                                  input logic blank, input logic odd, input int mode,
                                  input logic win, input logic pix, input logic bk);
    int v, c, filled;
    v = raw >> (8 - ind);
    c = 0;
    filled = 0;
    while (filled < 8) begin
      c = (c << ind) | v;
      filled += ind;
    end
    c = c >> (filled - 8);
    if (blank) c = 0;
    if (odd && mode != 0) begin
      if (mode == 1) c = c - c / 4;
      else if (mode == 2) c = c / 2;
      else c = c / 4;
    end
    if (win && pix) c = 255;
    else if (win) begin
      c = c / 2 + (bk ? tint : 0);
      if (c > 255) c = 255;
    end
    return c >> (8 - outd);
  endfunction

  function automatic logic [31:0] exp_pack(input int ind, input int outd, input int tint);
    logic blank;
    int r, g, b;
    blank = !(lat.hde && lat.vde);
    r = exp_chan(int'(lat.r), ind, outd, tint, blank, lat_odd, int'(lat.mode), lat.win, lat.pix, lat.bk[2]);
    g = exp_chan(int'(lat.g), ind, outd, tint, blank, lat_odd, int'(lat.mode), lat.win, lat.pix, lat.bk[1]);
    b = exp_chan(int'(lat.b), ind, outd, tint, blank, lat_odd, int'(lat.mode), lat.win, lat.pix, lat.bk[0]);
    return {4'b0, m_ce, lat.hs, lat.vs, m_de, 8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic hchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hchk("cycle_dut6", {4'b0, ce6, hs6, vs6, de6, 8'(r6), 8'(g6), 8'(b6)}, exp_pack(6, 6, 'h30));
      hchk("cycle_dut8", {4'b0, ce8, hs8, vs8, de8, r8, g8, b8}, exp_pack(8, 8, 'h30));
      hchk("cycle_dut4", {4'b0, ce4, hs4, vs4, de4, 8'(r4), 8'(g4), 8'(b4)}, exp_pack(4, 3, 'hA0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    ce_cnt++;
    ce_pix = ce_cnt[1];
  endtask

  task automatic run_line(input logic vs_line, input logic vb, input logic vb2, input logic chk,
                          input logic hb_chk, input logic [23:0] exp_even,
                          input logic [23:0] exp_odd, input int l);
    for (int i = 0; i < 16; i++) begin
      step();
      hblank = 1'b1;
      hsync  = (i >= 4 && i < 12);
      vsync  = vs_line && (i >= 4);
      vblank = vb;
      if (hb_chk && i == 15) hchk("hblank_rgb_de", {7'b0, de8, r8, g8, b8}, 32'h0);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      hblank = 1'b0;
      hsync  = 1'b0;
      vsync  = vs_line;
      vblank = (i < 20) ? vb : vb2;
    end
    if (chk)
      hchk($sformatf("line%0d_rgb8", l), {8'h0, r8, g8, b8},
           {8'h0, ((l % 2) != 0) ? exp_odd : exp_even});
  endtask

  task automatic run_frame(input logic chk, input logic hb_chk, input logic [23:0] exp_even,
                           input logic [23:0] exp_odd);
    for (int l = 0; l < 6; l++)
      run_line(l == 0, l < 2, l < 2, chk && l >= 2, hb_chk && l >= 2, exp_even, exp_odd, l);
  endtask

  task automatic count_ce(input int exp, input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (ce8) n++;
    end
    hchk(nm, n, exp);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with ce_pix toggling, then first frame in level mode.
    for (int i = 0; i < 4; i++) step();
    hchk("reset_dut6", {ce6, hs6, vs6, de6, r6, g6, b6}, 32'h0);
    hchk("reset_dut8", {ce8, hs8, vs8, de8, r8, g8, b8}, 32'h0);
    hchk("reset_dut4", {ce4, hs4, vs4, de4, r4, g4, b4}, 32'h0);
    step();
    rst = 1'b0;
    count_ce(8, "level_mode_ce_count");

    // Full-range colours through 6-bit path; second frame is edge mode.
    rin = 8'hFC; gin = 8'h80; bin = 8'h00;
    run_frame(1'b0, 1'b0, 24'h0, 24'h0);
    run_frame(1'b1, 1'b0, 24'hFC8000, 24'hFC8000);
    hchk("dut6_rgb", {8'h0, 8'(r6), 8'(g6), 8'(b6)}, 32'h003F2000);
    count_ce(4, "edge_mode_ce_count");

    // 50 % scanlines on odd lines.
    rin = 8'hC8; smode = 2'd2;
    run_frame(1'b1, 1'b0, 24'hC88000, 24'h644000);

    // OSD background tint, then OSD foreground over 25 % scanlines.
    smode = 2'd0; owin = 1'b1; obk = 3'b100; rin = 8'hF0; gin = 8'h40; bin = 8'h80;
    run_frame(1'b1, 1'b0, 24'hA82040, 24'hA82040);
    opix = 1'b1; smode = 2'd3;
    run_frame(1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
    owin = 1'b0; opix = 1'b0; obk = 3'b000; smode = 2'd0;

    // Blanking and DE behaviour around mid-line VBlank changes.
    rin = 8'hFC; gin = 8'h80; bin = 8'h00;
    run_frame(1'b1, 1'b1, 24'hFC8000, 24'hFC8000);
    run_line(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 0);
    hchk("de_hold_high", 32'(de8), 32'h1);
    hchk("vb_mid_blank", 32'(r8), 32'h0);
    run_line(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 0);
    hchk("de_hold_low", 32'(de8), 32'h0);
    hchk("vb_mid_colour", 32'(r8), 32'hFC);
    run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 0);
    hchk("de_next_line", 32'(de8), 32'h1);

    // Narrow depths and tint saturation.
    rin = 8'hA0;
    run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 0);
    hchk("dut4_r_expand", 32'(r4), 32'h5);
    owin = 1'b1; obk = 3'b111; rin = 8'hFE;
    run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 0);
    hchk("dut4_r_saturate", 32'(r4), 32'h7);
    hchk("dut8_r_tint", 32'(r8), 32'hAF);
    owin = 1'b0; obk = 3'b000; rin = 8'hFC;

    // Mid-line asynchronous reset.
    for (int i = 0; i < 26; i++) begin
      step();
      hblank = (i < 16);
      vblank = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    hchk("midreset_dut8", {ce8, hs8, vs8, de8, r8, g8, b8}, 32'h0);
    hchk("midreset_dut6", {ce6, hs6, vs6, de6, r6, g6, b6}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      hchk("midreset_ce_low", 32'(ce8), 32'h0);
    end
    step();
    rst = 1'b0;
    count_ce(8, "level_after_midreset");
    run_frame(1'b1, 1'b0, 24'hFC8000, 24'hFC8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
